// File: rtl/entrada_fpga_pkg.sv
// rtl/entrada_fpga_pkg.sv - shared state encoding, display codes and sizing helper for the decimal input path
package entrada_fpga_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BLANK   = 4'b1111;
    localparam logic [3:0] MAX_BCD = 4'd9;

    // Bits needed to hold the largest DIGITS-digit decimal value: ceil(log2(10^DIGITS)).
    function automatic int acc_width(input int digits);
        longint p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return $clog2(p);
    endfunction

endpackage

// File: rtl/entrada_fpga_debounce_botao.sv
// rtl/entrada_fpga_debounce_botao.sv - active-low button synchronizer, debouncer and press-event pulse
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2;
    logic          stable, stable_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
        end else begin
            sync1       <= btn;
            sync2       <= sync1;
            stable_prev <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This cycle is the DEBOUNCE_CYCLES-th consecutive disagreement.
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable_prev & ~stable;

endmodule

// File: rtl/entrada_fpga.sv
// rtl/entrada_fpga.sv - collects decimal digits from switches/buttons and returns the binary value to the processor
module entrada_fpga
    import entrada_fpga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DIGITS          = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sinal_in,
    input  logic [3:0]  sw_digit,
    input  logic        btn_digit,
    input  logic        btn_enter,
    output logic [31:0] valor_entrada,
    output logic        pronto,
    output logic        aguardando,
    output logic [3:0]  dp4,
    output logic [3:0]  dp3,
    output logic [3:0]  dp2,
    output logic [3:0]  dp1
);

    localparam int ACC_W = acc_width(DIGITS);
    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]   count;
    logic               digit_ev, enter_ev, digit_ok, active;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_digit (
        .clock (clock),
        .reset (reset),
        .btn   (btn_digit),
        .press (digit_ev)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
        .clock (clock),
        .reset (reset),
        .btn   (btn_enter),
        .press (enter_ev)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pronto     = 1'b0;
        aguardando = 1'b0;
        case (state_q)
            S_IDLE: if (sinal_in) state_d = S_WAIT;
            S_WAIT: begin
                aguardando = 1'b1;
                if (!sinal_in)     state_d = S_IDLE;
                else if (enter_ev) state_d = S_DONE;
            end
            S_DONE: begin
                pronto = 1'b1;
                if (!sinal_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A digit arriving with enter in the same cycle is folded in before capture.
    always_comb begin
        active   = (state_q == S_WAIT) && sinal_in;
        digit_ok = digit_ev && (sw_digit <= MAX_BCD) && (count < CNT_W'(DIGITS));
        acc_next = acc;
        if (digit_ok)
            acc_next = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, sw_digit};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc           <= '0;
            count         <= '0;
            valor_entrada <= '0;
            dp4 <= BLANK;
            dp3 <= BLANK;
            dp2 <= BLANK;
            dp1 <= BLANK;
        end else if (state_q == S_IDLE && sinal_in) begin
            acc   <= '0;
            count <= '0;
            dp4 <= BLANK;
            dp3 <= BLANK;
            dp2 <= BLANK;
            dp1 <= BLANK;
        end else if (active) begin
            if (digit_ok) begin
                acc   <= acc_next;
                count <= count + 1'b1;
                dp4   <= dp3;
                dp3   <= dp2;
                dp2   <= dp1;
                dp1   <= sw_digit;
            end
            if (enter_ev)
                valor_entrada <= {{(32-ACC_W){1'b0}}, acc_next};
        end
    end

endmodule

// File: tb/tb_entrada_fpga.sv
// tb/tb_entrada_fpga.sv - directed self-checking bench for entrada_fpga
module tb_entrada_fpga;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sinal_in = 1'b0;
    logic [3:0]  sw_digit = 4'd0;
    logic        btn_digit = 1'b1;
    logic        btn_enter = 1'b1;
    logic [31:0] valor_entrada;
    logic        pronto, aguardando;
    logic [3:0]  dp4, dp3, dp2, dp1;

    int n_checks = 0;
    int n_pass   = 0;
    int pronto_cycles = 0;
    int pronto_before;

    entrada_fpga #(.DEBOUNCE_CYCLES(4), .DIGITS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .sinal_in      (sinal_in),
        .sw_digit      (sw_digit),
        .btn_digit     (btn_digit),
        .btn_enter     (btn_enter),
        .valor_entrada (valor_entrada),
        .pronto        (pronto),
        .aguardando    (aguardando),
        .dp4           (dp4),
        .dp3           (dp3),
        .dp2           (dp2),
        .dp1           (dp1)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (pronto) pronto_cycles++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input bit is_enter, input logic [3:0] d);
        sw_digit = d;
        if (is_enter) btn_enter = 1'b0; else btn_digit = 1'b0;
        step(8);
        btn_enter = 1'b1;
        btn_digit = 1'b1;
        step(8);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pronto"}, {31'd0, pronto}, 32'd0);
        check({tag, "_aguard"}, {31'd0, aguardando}, 32'd0);
        check({tag, "_valor"}, valor_entrada, 32'd0);
        check({tag, "_dp"}, {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_FFFF);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        step(10);
        check_reset_values("rst");

        // Normal entry 1234
        sinal_in = 1'b1;
        step(1);
        check("wait_led", {31'd0, aguardando}, 32'd1);
        press(0, 4'd1); press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
        press(1, 4'd0);
        check("norm_valor", valor_entrada, 32'h0000_04D2);
        check("norm_pronto", {31'd0, pronto}, 32'd1);
        check("norm_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_1234);
        sinal_in = 1'b0;
        check("norm_pronto_hold", {31'd0, pronto}, 32'd1);
        step(1);
        check("norm_pronto_drop", {31'd0, pronto}, 32'd0);
        check("norm_idle_led", {31'd0, aguardando}, 32'd0);
        step(2);

        // Overflow: fifth digit ignored
        sinal_in = 1'b1;
        step(1);
        press(0, 4'd9); press(0, 4'd9); press(0, 4'd9); press(0, 4'd9); press(0, 4'd7);
        press(1, 4'd0);
        check("ovf_valor", valor_entrada, 32'd9999);
        check("ovf_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_9999);
        sinal_in = 1'b0;
        step(3);

        // Glitch and illegal digit
        sinal_in = 1'b1;
        step(1);
        sw_digit = 4'd5;
        btn_digit = 1'b0;
        step(3);
        btn_digit = 1'b1;
        step(10);
        check("glitch_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_FFFF);
        press(0, 4'd12);
        check("illegal_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_FFFF);
        press(0, 4'd3);
        check("after_illegal_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_FFF3);
        press(1, 4'd0);
        check("after_illegal_valor", valor_entrada, 32'd3);
        sinal_in = 1'b0;
        step(3);

        // Enter with no digits
        sinal_in = 1'b1;
        step(1);
        press(1, 4'd0);
        check("empty_valor", valor_entrada, 32'd0);
        check("empty_pronto", {31'd0, pronto}, 32'd1);
        sinal_in = 1'b0;
        step(3);

        // Entry 1234 again, then a digit while idle
        sinal_in = 1'b1;
        step(1);
        press(0, 4'd1); press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
        press(1, 4'd0);
        sinal_in = 1'b0;
        step(3);
        press(0, 4'd7);
        check("idle_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_1234);
        check("idle_valor", valor_entrada, 32'd1234);

        // Abort after one digit
        pronto_before = pronto_cycles;
        sinal_in = 1'b1;
        step(1);
        press(0, 4'd5);
        check("abort_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_FFF5);
        sinal_in = 1'b0;
        step(3);
        check("abort_led", {31'd0, aguardando}, 32'd0);
        check("abort_valor", valor_entrada, 32'd1234);
        check("abort_no_pronto", pronto_cycles - pronto_before, 32'd0);

        // Reset in the middle of an entry
        sinal_in = 1'b1;
        step(1);
        press(0, 4'd8);
        check("mid_dp", {16'd0, dp4, dp3, dp2, dp1}, 32'h0000_FFF8);
        reset = 1'b1;
        sinal_in = 1'b0;
        step(2);
        reset = 1'b0;
        step(2);
        check_reset_values("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
